// File: rtl/fifo_128_merge_pkg.sv
// fifo_128_merge_pkg
//   Constants and types shared by the 128-point stage blocks: float and
//   complex word widths, the frame depth and its address width, and the
//   output serializer state type.
package fifo_128_merge_pkg;

  localparam int float_len = 32;
  localparam int cplx_len  = float_len * 2;
  localparam int depth     = 128;
  localparam int addr_len  = $clog2(depth);

  typedef logic [cplx_len-1:0] cplx_t;
  typedef logic [addr_len-1:0] addr_t;

  localparam addr_t last_addr = addr_t'(depth - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bram_sdp_128x64.sv
// bram_sdp_128x64
//   Simple dual-port RAM, depth x cplx_len, one write port and one read
//   port with a registered read (1-cycle latency). No reset on the array or
//   the read register so it maps onto block RAM.
// Ports:
//   clk      rising-edge clock
//   wr_en    write enable
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read enable; rd_data holds when low
//   rd_addr  read address
//   rd_data  registered read data
module bram_sdp_128x64
  import fifo_128_merge_pkg::*;
(
  input  logic                clk,
  input  logic                wr_en,
  input  logic [addr_len-1:0] wr_addr,
  input  logic [cplx_len-1:0] wr_data,
  input  logic                rd_en,
  input  logic [addr_len-1:0] rd_addr,
  output logic [cplx_len-1:0] rd_data
);

  cplx_t mem [depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_128_merge.sv
// fifo_128_merge
//   Butterfly output serializer. Each accepted (y1, y2) pair emits y1 on the
//   next cycle and stores y2; after depth pairs the stored y2 values are
//   replayed back-to-back, giving one in-order 2*depth sample stream.
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   data_in1        butterfly output y1
//   data_in2        butterfly output y2
//   data_in_valid   pair valid this cycle
//   ready           high when a pair may be accepted (not draining)
//   data_out        serialized sample (holds when data_out_valid is low)
//   data_out_valid  data_out valid this cycle
//   overrun         sticky: a valid pair arrived while ready was low
module fifo_128_merge
  import fifo_128_merge_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [cplx_len-1:0] data_in1,
  input  logic [cplx_len-1:0] data_in2,
  input  logic                data_in_valid,
  output logic                ready,
  output logic [cplx_len-1:0] data_out,
  output logic                data_out_valid,
  output logic                overrun
);

  state_t state, state_nxt;
  addr_t  wr_cnt, rd_cnt;
  cplx_t  y1_q, ram_dout;
  logic   accept, rd_issue;
  logic   sel_ram;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rd_issue  = 1'b0;
    ready     = 1'b1;
    case (state)
      IDLE, FILL: begin
        if (data_in_valid) begin
          accept    = 1'b1;
          state_nxt = (wr_cnt == last_addr) ? DRAIN : FILL;
        end
      end
      DRAIN: begin
        ready    = 1'b0;
        rd_issue = 1'b1;
        if (rd_cnt == last_addr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt         <= '0;
      rd_cnt         <= '0;
      y1_q           <= '0;
      sel_ram        <= 1'b0;
      data_out_valid <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (accept) begin
        wr_cnt <= wr_cnt + addr_t'(1);
        y1_q   <= data_in1;
      end
      if (rd_issue) rd_cnt <= rd_cnt + addr_t'(1);
      data_out_valid <= accept | rd_issue;
      // The mux keeps pointing at whichever source produced the last valid
      // sample, so data_out holds through idle cycles (RAM dout holds too).
      if (accept)        sel_ram <= 1'b0;
      else if (rd_issue) sel_ram <= 1'b1;
      if (data_in_valid && !ready) overrun <= 1'b1;
    end
  end

  bram_sdp_128x64 u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_cnt),
    .wr_data (data_in2),
    .rd_en   (rd_issue),
    .rd_addr (rd_cnt),
    .rd_data (ram_dout)
  );

  assign data_out = sel_ram ? ram_dout : y1_q;

endmodule

// File: tb/tb_fifo_128_merge.sv
module tb_fifo_128_merge;
  import fifo_128_merge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data_in1 = '0;
  logic [63:0] data_in2 = '0;
  logic        data_in_valid = 1'b0;
  logic        ready;
  logic [63:0] data_out;
  logic        data_out_valid;
  logic        overrun;

  fifo_128_merge dut (
    .clk            (clk),
    .rst            (rst),
    .data_in1       (data_in1),
    .data_in2       (data_in2),
    .data_in_valid  (data_in_valid),
    .ready          (ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [63:0] d;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] y2_buf[$];
  int          drain_left = 0;
  bit          exp_ovr = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every valid output must match the head of the queue,
  // both in value and in the cycle it was predicted to appear.
  always @(negedge clk) begin
    if (rst === 1'b0 && data_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %h expected none (cycle %0d)", data_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", data_out, e.d);
        chk("out_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // One input cycle. Model: a frame is depth accepted pairs; y1 comes out the
  // next cycle, then all y2 follow contiguously; the depth cycles after the
  // last pair of a frame refuse input and any valid pair there is dropped.
  task automatic drive(input bit v, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    #1;
    chk("ready", 64'(ready), 64'(drain_left == 0));
    chk("overrun", 64'(overrun), 64'(exp_ovr));
    data_in_valid = v;
    data_in1      = a;
    data_in2      = b;
    if (drain_left > 0) begin
      drain_left--;
      if (v) exp_ovr = 1'b1;
    end else if (v) begin
      exp_t e;
      e.d = a;
      e.cyc = cyc + 1;
      exp_q.push_back(e);
      y2_buf.push_back(b);
      if (y2_buf.size() == depth) begin
        for (int k = 0; k < depth; k++) begin
          e.d = y2_buf[k];
          e.cyc = cyc + 2 + k;
          exp_q.push_back(e);
        end
        y2_buf.delete();
        drain_left = depth;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    data_in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    y2_buf.delete();
    drain_left = 0;
    exp_ovr = 1'b0;
    chk("rst_valid", 64'(data_out_valid), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_data", data_out, 64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    do_reset();

    // Counting frame, gap-free.
    for (int k = 0; k < depth; k++) drive(1'b1, 64'(k), 64'(1000 + k));
    idle(135);

    // Valid every other cycle.
    for (int k = 0; k < 2 * depth; k++) drive(k % 2 == 0, rnd64(), rnd64());
    idle(135);

    // Random gaps.
    for (int k = 0; k < 3 * depth; k++) drive($urandom_range(0, 3) != 0, rnd64(), rnd64());
    idle(135);

    // Valid held high through the drain window and into a second frame.
    for (int k = 0; k < 3 * depth; k++) drive(1'b1, rnd64(), rnd64());
    idle(135);

    // Two frames with the second starting right as the drain ends.
    do_reset();
    for (int k = 0; k < depth; k++) drive(1'b1, rnd64(), rnd64());
    idle(depth);
    for (int k = 0; k < depth; k++) drive(1'b1, rnd64(), rnd64());
    idle(135);

    // Reset in the middle of a drain, then a fresh frame.
    for (int k = 0; k < depth; k++) drive(1'b1, rnd64(), rnd64());
    idle(42);
    do_reset();
    for (int k = 0; k < depth; k++) drive(1'b1, rnd64(), rnd64());
    idle(135);

    // Reset after 50 pairs of a frame, then a full new frame.
    for (int k = 0; k < 50; k++) drive(1'b1, rnd64(), rnd64());
    do_reset();
    for (int k = 0; k < depth; k++) drive(1'b1, rnd64(), rnd64());
    idle(135);

    chk("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_128_merge.md
# fifo_128_merge

Radix-2 butterfly output serializer for the 128-point stage. It accepts the butterfly result pairs (y1, y2) on two parallel 64-bit complex buses. It emits y1 immediately and buffers y2 in a 128-entry RAM, then replays all 128 buffered y2 values back-to-back. The result is a single in-order 256-sample stream for the next stage's pairing FIFO. It is the inverse of the stage-input pairing FIFO: 2-to-1 where that block is 1-to-2.

## Interface
- float_len, 32, width of one float; a complex sample is float_len*2 bits (real in upper half)
- depth, 128, pairs per frame; equals half the stage span
- addr_len, 7, log2(depth)

Clocking and reset are fixed: one clock; reset is synchronous and active-high.

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- data_in1  in  float_len*2  butterfly output y1
- data_in2  in  float_len*2  butterfly output y2
- data_in_valid  in  1  pair valid this cycle
- ready  out  1  high when a pair may be accepted (state != DRAIN)
- data_out  out  float_len*2  serialized sample
- data_out_valid  out  1  data_out valid this cycle
- overrun  out  1  sticky flag: a valid pair arrived while ready was low

## Operation
- States are IDLE, FILL and DRAIN. Reset enters IDLE with wr_cnt = 0 and rd_cnt = 0.
- A pair is accepted when data_in_valid = 1 and state is IDLE or FILL.
  - data_in1 is registered to data_out with data_out_valid = 1.
  - data_in2 is written to RAM[wr_cnt], then wr_cnt increments.
- IDLE -> FILL on the first accepted pair, unless depth = 1.
- FILL stays in FILL while wr_cnt < depth-1 after acceptance. Gaps in data_in_valid are allowed; data_out_valid simply goes low for the gap cycles.
- FILL -> DRAIN on the cycle that accepts pair depth-1 (wr_cnt = 127). wr_cnt wraps to 0.
- In DRAIN, read address rd_cnt = 0..127 is issued on consecutive cycles with no gaps. rd_cnt wraps to 0.
- DRAIN -> IDLE on the cycle that issues address 127.
- A valid pair during DRAIN is dropped: no RAM write and no output. overrun is set and stays high until rst.
- Arithmetic is pass-through only. No width change and no rounding.
- rst mid-frame:
  - returns to IDLE and clears counters, data_out_valid and overrun;
  - discards buffered y2 data (RAM contents are don't-care, never replayed).

## Timing
- Reset values: data_out = 0, data_out_valid = 0, overrun = 0, ready = 1.
- y1 latency is 1 cycle: a pair accepted at cycle c gives data_out = y1 at c+1.
- Let t be the cycle the 128th pair is accepted.
  - y1[127] is output at t+1.
  - Read addresses 0..127 are issued at t+1..t+128 (1-cycle RAM read plus an output mux).
  - y2[0..127] are output at t+2..t+129.
- The output stream is contiguous from y1[127] through y2[127]. With gap-free input this gives 256 consecutive valid cycles.
- ready is low from t+1 through t+128 and high again at t+129. A pair accepted at t+129 outputs its y1 at t+130, with no collision with y2[127].
- Write and read never target the same address in the same cycle, so no RAM collision handling is needed.
- data_out holds its last value when data_out_valid = 0.

## Structure
- Shared package holds:
  - float_len and the complex word width (float_len*2);
  - the depth and addr_len constants shared with the stage-input FIFO and the twiddle ROM.
- One sub-module, bram_sdp_128x64:
  - simple dual-port RAM with a write port, a read port and a 1-cycle registered read;
  - infers block RAM.
- The FSM, counters and output mux are in the top module. The output mux selects y1 in IDLE/FILL and RAM dout one cycle after each DRAIN read.

## Test plan
- Reset then 128 gap-free pairs, y1 = k and y2 = 1000+k:
  - data_out = 0..127 at cycles 1..128, then 1000..1127 at cycles 129..256;
  - valid is high for 256 consecutive cycles;
  - ready is low for 128 cycles.
- Same frame with valid toggling every other cycle:
  - y1 values appear only on valid cycles, in order;
  - the y2 drain is still 128 gap-free cycles after the last y1.
- Valid held high through DRAIN:
  - pairs in DRAIN are dropped and overrun rises one cycle after the first dropped pair and stays high;
  - the drained y2 sequence is unchanged.
- Two frames separated by exactly the 128-cycle DRAIN (second frame starts at t+129):
  - 512 outputs in order frame1-y1, frame1-y2, frame2-y1, frame2-y2;
  - overrun = 0.
- rst asserted mid-DRAIN (after y2[40]):
  - the next cycle has data_out_valid = 0, ready = 1, overrun = 0;
  - a fresh frame then serializes correctly with no stale y2.
- rst asserted mid-FILL after 50 pairs, then a full new frame:
  - output is exactly the new frame's 256 samples.
